// File: rtl/sh_riscv_pkg.sv
// rtl/sh_riscv_pkg.sv - shared RISC-V fetch types and constants
package sh_riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [ILEN-1:0] INSTR_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            err;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/sh_fetch_queue.sv
// rtl/sh_fetch_queue.sv - in-order fetch queue with separate alloc/fill/pop pointers
module sh_fetch_queue
    import sh_riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [ILEN-1:0] fill_instr,
    input  logic            fill_err,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head_entry,
    output logic [PW-1:0]   count,
    output logic [PW-1:0]   pending
);

    localparam int AW = PW - 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] tail_ptr;

    logic [AW-1:0] head_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] tail_idx;

    assign head_idx = head_ptr[AW-1:0];
    assign fill_idx = fill_ptr[AW-1:0];
    assign tail_idx = tail_ptr[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                mem[tail_idx].pc     <= alloc_pc;
                mem[tail_idx].filled <= 1'b0;
                tail_ptr             <= tail_ptr + PW'(1);
            end
            if (fill) begin
                mem[fill_idx].instr  <= fill_instr;
                mem[fill_idx].err    <= fill_err;
                mem[fill_idx].filled <= 1'b1;
                fill_ptr             <= fill_ptr + PW'(1);
            end
            // Clearing on pop keeps a stale filled bit from showing through once the queue drains.
            if (pop) begin
                mem[head_idx].filled <= 1'b0;
                head_ptr             <= head_ptr + PW'(1);
            end
        end
    end

    assign head_entry = mem[head_idx];
    assign count      = tail_ptr - head_ptr;
    assign pending    = tail_ptr - fill_ptr;

endmodule

// File: rtl/sh_riscv_fetch_q.sv
// rtl/sh_riscv_fetch_q.sv - PC generator, imem request issue and redirect handling
module sh_riscv_fetch_q
    import sh_riscv_pkg::ILEN, sh_riscv_pkg::RESET_VECTOR, sh_riscv_pkg::fetch_entry_t;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_err
);

    localparam int PW = $clog2(FQ_DEPTH) + 1;

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FQ_DEPTH must be a power of 2 and at least 2");
    end

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   drop_cnt;
    logic [PW-1:0]   count;
    logic [PW-1:0]   pending;
    logic [PW:0]     in_use;
    logic [PW:0]     outstanding;
    logic            req_fire;
    logic            rsp_take;
    logic            pop;
    fetch_entry_t    head_entry;

    // Dropped-but-unreturned requests still occupy memory slots, so they count against the cap.
    assign in_use      = {1'b0, count} + {1'b0, drop_cnt};
    assign outstanding = {1'b0, pending} + {1'b0, drop_cnt};

    assign imem_req_valid = !reset && !stall && !redirect_valid && (in_use < (PW+1)'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    assign out_valid = head_entry.filled && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;
    assign out_err   = head_entry.err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            drop_cnt <= drop_cnt + pending - PW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && (outstanding == '0)));
        end
    end

    sh_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_take),
        .fill_instr (imem_rsp_data),
        .fill_err   (imem_rsp_err),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_entry (head_entry),
        .count      (count),
        .pending    (pending)
    );

endmodule

// File: tb/tb_sh_riscv_fetch_q.sv
// tb/tb_sh_riscv_fetch_q.sv - self-checking bench for sh_riscv_fetch_q
module tb_sh_riscv_fetch_q;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_err;

    always #5 clk = ~clk;

    sh_riscv_fetch_q #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_err        (out_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        bit do_reset;
        int lat;
        bit stall;
        bit ready;
        int cycles;
        int exp_hs;
        int exp_out;
    } row_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    row_t        tab[7];
    int          n_tests = 0;
    int          n_fail = 0;
    int          lat = 1;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          out_cnt = 0;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Fixed-latency in-order memory
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reset) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            imem_rsp_err   = (mq[0].addr == ERR_ADDR);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            imem_rsp_err   = 1'b0;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_pc);
                mq.push_back('{imem_req_addr, cyc + lat});
                sb.push_back('{exp_pc, mem_word(exp_pc), exp_pc == ERR_ADDR});
                exp_pc = exp_pc + 32'd4;
                hs_cnt++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected got pc %h exp none", out_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    chk("out_err", 32'(out_err), 32'(e.err));
                end
            end
            if (redirect_valid) begin
                chk("redir_no_pop", 32'(out_valid), 0);
                chk("redir_no_req", 32'(imem_req_valid), 0);
                sb.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        sb.delete();
        exp_pc = RESET_PC;
        reset  = 1'b0;
        #1;
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_first_req", 32'(imem_req_valid), 1);
        chk("rst_out_valid_rel", 32'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        //            rst   lat stall  ready  cyc hs out
        tab[0] = '{1'b1, 1, 1'b0, 1'b1, 20, 20, 18};
        tab[1] = '{1'b1, 1, 1'b0, 1'b0, 10,  4,  0};
        tab[2] = '{1'b0, 1, 1'b0, 1'b1, 12, 11, 12};
        tab[3] = '{1'b1, 1, 1'b0, 1'b1,  8,  8,  6};
        tab[4] = '{1'b0, 1, 1'b1, 1'b1,  5,  0,  2};
        tab[5] = '{1'b0, 1, 1'b0, 1'b1, 10, 10,  8};
        tab[6] = '{1'b1, 3, 1'b0, 1'b1, 12, 10,  7};

        for (int i = 0; i < 7; i++) begin
            if (tab[i].do_reset) begin
                lat = tab[i].lat;
                do_reset();
            end
            stall     = tab[i].stall;
            out_ready = tab[i].ready;
            hs_cnt    = 0;
            out_cnt   = 0;
            repeat (tab[i].cycles) tick();
            chk($sformatf("row%0d_req_handshakes", i), hs_cnt, tab[i].exp_hs);
            chk($sformatf("row%0d_outputs", i), out_cnt, tab[i].exp_out);
        end

        // Redirect with three requests in flight on a 3-cycle memory
        lat = 3;
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        hs_cnt  = 0;
        out_cnt = 0;
        tick();
        redirect_valid = 1'b0;
        repeat (11) tick();
        chk("redir3_req_handshakes", hs_cnt, 9);
        chk("redir3_outputs", out_cnt, 6);

        // Redirect landing on a response while decode is ready
        lat = 1;
        do_reset();
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        hs_cnt  = 0;
        out_cnt = 0;
        tick();
        redirect_valid = 1'b0;
        repeat (9) tick();
        chk("redir_rsp_req_handshakes", hs_cnt, 9);
        chk("redir_rsp_outputs", out_cnt, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
